// File: rtl/color_event_fifo.sv
// Watches the colour vector {green, pink, black} and queues a timestamped record on every change.
// Records drain over a valid/ready stream; events arriving while full are dropped and counted.
module color_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_srst_n,
  input  logic                         i_green,
  input  logic                         i_pink,
  input  logic [1:0]                   i_black,
  input  logic                         i_clear,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [TS_W+3:0]              o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_overflow,
  output logic [7:0]                   o_dropCount
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned DataW = TS_W + 4;

  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [3:0]       snap;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [3:0]       prev_q;
  logic             primed_q;
  logic [DataW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic             evt;
  logic             pop;
  logic             push;
  logic             drop;

  assign snap = {i_green, i_pink, i_black};

  always_comb begin
    evt  = primed_q && (snap != prev_q);
    pop  = (count_q != '0) && i_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    push = evt && ((count_q != DepthC) || pop);
    drop = evt && !push;
  end

  always_comb begin
    ts_d     = ts_q + TS_W'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear wins over history but not over a drop in the same cycle.
  always_comb begin
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (i_clear) begin
      overflow_d = drop;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      ts_q       <= '0;
      prev_q     <= '0;
      primed_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ts_q       <= ts_d;
      prev_q     <= snap;
      primed_q   <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {ts_q, snap};
      end
    end
  end

  assign o_valid     = (count_q != '0);
  assign o_data      = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_count     = count_q;
  assign o_overflow  = overflow_q;
  assign o_dropCount = drop_cnt_q;

endmodule
